// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: single-word fetch over a req/ready/rvalid bus into the IR.
// Optional stalled-fetch abort is enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_ctrl #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSN       = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] instr_pc,
    output logic        ir_valid,
    output logic        pc_write,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
    state_t state;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("ifetch_ctrl: TIMEOUT_CYCLES must be in 2..255");
    end

`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] cnt;
    logic       timeout;
    // Fires in the last allowed REQ/WAIT cycle so ERR is entered on the next edge.
    assign timeout = (cnt + 8'd1) == 8'(TIMEOUT_CYCLES);
`endif

    // mem_addr doubles as the pending-PC register: it is only loaded for aligned PCs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            ir          <= NOP_INSN;
            instr_pc    <= 32'h80000000;
            ir_valid    <= 1'b0;
            pc_write    <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'd0;
`ifdef IFETCH_TIMEOUT_EN
            cnt         <= 8'd0;
`endif
        end else begin
            ir_valid <= 1'b0;
            pc_write <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        busy <= 1'b1;
                        if (pc[1:0] == 2'b00) begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
`ifdef IFETCH_TIMEOUT_EN
                            cnt      <= 8'd0;
`endif
                        end else begin
                            state       <= ERR;
                            fault       <= 1'b1;
                            fault_cause <= 2'd0;
                            ir          <= NOP_INSN;
                            instr_pc    <= pc;
                        end
                    end
                end
                REQ: begin
`ifdef IFETCH_TIMEOUT_EN
                    cnt <= cnt + 8'd1;
                    if (timeout) begin
                        state       <= ERR;
                        mem_req     <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= 2'd1;
                        ir          <= NOP_INSN;
                        instr_pc    <= mem_addr;
                    end else
`endif
                    if (mem_ready) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
`ifdef IFETCH_TIMEOUT_EN
                    cnt <= cnt + 8'd1;
`endif
                    if (mem_rvalid) begin
                        state    <= DONE;
                        ir       <= mem_rdata;
                        instr_pc <= mem_addr;
                        ir_valid <= 1'b1;
                        pc_write <= 1'b1;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (timeout) begin
                        state       <= ERR;
                        fault       <= 1'b1;
                        fault_cause <= 2'd1;
                        ir          <= NOP_INSN;
                        instr_pc    <= mem_addr;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized scoreboard bench for ifetch_ctrl: the driver queues expected IR updates/faults,
// an independent monitor checks every ir_valid/fault pulse and the bus invariants.
module tb_ifetch_ctrl;
`ifdef IFETCH_TIMEOUT_EN
    localparam int TO = 4;
    localparam int MAXD = 1;
`else
    localparam int TO = 16;
    localparam int MAXD = 4;
`endif
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0, rst = 1'b1;
    logic fetch_start = 1'b0, mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] pc = 32'h0, mem_rdata = 32'h0;
    logic mem_req, ir_valid, pc_write, busy, fault;
    logic [31:0] mem_addr, ir, instr_pc;
    logic [1:0] fault_cause;

    ifetch_ctrl #(.TIMEOUT_CYCLES(TO), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ir(ir), .instr_pc(instr_pc),
        .ir_valid(ir_valid), .pc_write(pc_write), .busy(busy), .fault(fault),
        .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_fault;
        logic [31:0] ir;
        logic [31:0] ipc;
        logic [1:0]  cause;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [31:0] exp_addr = 32'h0;
    bit          no_req = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit f, input logic [31:0] i, input logic [31:0] p,
                        input logic [1:0] c, input int t);
        exp_t e;
        e.is_fault = f; e.ir = i; e.ipc = p; e.cause = c; e.cyc = t;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per ir_valid/fault pulse, checks invariants every cycle.
    initial begin
        exp_t        e;
        logic [31:0] last_ir = NOP;
        bit          prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ir_valid || fault) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", {30'd0, ir_valid, fault}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_kind", 32'(fault), 32'(e.is_fault));
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("ir", ir, e.ir);
                        chk("instr_pc", instr_pc, e.ipc);
                        if (e.is_fault) chk("fault_cause", 32'(fault_cause), 32'(e.cause));
                    end
                    chk("pc_write_eq_ir_valid", 32'(pc_write), 32'(ir_valid));
                    chk("fault_excl_ir_valid", 32'(fault & ir_valid), 32'd0);
                end else begin
                    chk("pc_write_quiet", 32'(pc_write), 32'd0);
                    if (!prev_rst) chk("ir_stable", ir, last_ir);
                end
                if (mem_req) chk("mem_addr", mem_addr, exp_addr);
                if (no_req) chk("no_req_misaligned", 32'(mem_req), 32'd0);
            end
            last_ir  = ir;
            prev_rst = rst;
        end
    end

    // One complete fetch; noise adds ignored fetch_start pulses, stray adds discarded rvalids.
    task automatic fetch(input logic [31:0] p, input logic [31:0] d, input int rdly,
                         input int vdly, input bit stray, input bit noise);
        int t0;
        step();
        if (stray) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; end
        fetch_start = 1'b1;
        pc = p;
        t0 = cyc;
        if (p[1:0] != 2'b00) begin
            no_req = 1'b1;
            push(1'b1, NOP, p, 2'd0, t0 + 1);
            step();
            fetch_start = noise; pc = $urandom; mem_rvalid = 1'b0;
            @(negedge clk);
            chk("busy_err_cycle", 32'(busy), 32'd1);
            step();
            fetch_start = 1'b0;
            @(negedge clk);
            chk("busy_after_err", 32'(busy), 32'd0);
            no_req = 1'b0;
        end else begin
            exp_addr = p;
            push(1'b0, d, p, 2'd0, t0 + 3 + rdly + vdly);
            for (int i = 0; i <= rdly; i++) begin
                step();
                fetch_start = noise & 1'($urandom_range(0, 1));
                pc          = $urandom;
                mem_ready   = (i == rdly);
                mem_rvalid  = stray && (i == rdly);
                mem_rdata   = 32'hDEADBEEF;
            end
            for (int j = 0; j <= vdly; j++) begin
                step();
                fetch_start = noise & 1'($urandom_range(0, 1));
                mem_ready   = 1'b0;
                mem_rvalid  = (j == vdly);
                mem_rdata   = (j == vdly) ? d : $urandom;
            end
            step();
            mem_rvalid  = 1'b0;
            fetch_start = noise & 1'($urandom_range(0, 1));
            step();
            fetch_start = 1'b0;
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        repeat (3) step();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ir", ir, NOP);
        chk("rst_instr_pc", instr_pc, 32'h80000000);
        chk("rst_pulses", {28'd0, ir_valid, pc_write, fault, busy}, 32'd0);
        chk("rst_fault_cause", 32'(fault_cause), 32'd0);
        step();
        rst = 1'b0;

        fetch(32'h80000000, 32'h00500093, 0, 0, 1'b0, 1'b0);
`ifndef IFETCH_TIMEOUT_EN
        fetch(32'h80000004, 32'h00a00113, 3, 2, 1'b0, 1'b1);
`endif
        fetch(32'h80000002, 32'h0, 0, 0, 1'b0, 1'b1);
        chk("misaligned_ir", ir, NOP);
        fetch(32'h80000008, 32'h002081b3, 0, 0, 1'b1, 1'b0);

        // Reset during WAIT drops the outstanding request.
        step();
        fetch_start = 1'b1; pc = 32'h8000000C; exp_addr = 32'h8000000C;
        step();
        fetch_start = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_mem_req", 32'(mem_req), 32'd0);
        chk("rstw_ir", ir, NOP);
        chk("rstw_instr_pc", instr_pc, 32'h80000000);
        fetch(32'h80000010, 32'h40000033, 1, 1, 1'b0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            p = $urandom;
            if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
            fetch(p, $urandom, $urandom_range(0, MAXD), $urandom_range(0, MAXD),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef IFETCH_TIMEOUT_EN
        begin
            int t0;
            step();
            fetch_start = 1'b1; pc = 32'h80000100; exp_addr = 32'h80000100; t0 = cyc;
            push(1'b1, NOP, 32'h80000100, 2'd1, t0 + 5);
            step();
            fetch_start = 1'b0; mem_ready = 1'b0;
            repeat (4) step();
            @(negedge clk);
            chk("to_mem_req_err", 32'(mem_req), 32'd0);
            step();
            mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
            @(negedge clk);
            chk("to_busy_idle", 32'(busy), 32'd0);
            step();
            mem_rvalid = 1'b0;
        end
`endif

        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
